// File: rtl/ad_pkt_encoder_pkg.sv
// Shared widths, default header word and helpers for the AD packet encoder.
package ad_pkt_encoder_pkg;

  // TX buffer word index width (256 words per bank) and data width
  localparam int unsigned USB_ADDR_NBIT   = 8;
  localparam int unsigned USB_DATA_NBIT   = 16;

  // TX buffer address is {bank, word index}
  localparam int unsigned TX_ADDR_NBIT    = USB_ADDR_NBIT + 1;

  // Largest payload that still leaves room for 3 header words and the checksum
  localparam int unsigned MAX_PKT_SAMPLES = 252;

  // Default value of packet word 0
  localparam logic [USB_DATA_NBIT-1:0] PKT_HDR_DEFAULT = 16'hA55A;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [USB_DATA_NBIT-1:0] sat_inc(input logic [USB_DATA_NBIT-1:0] v);
    return (v == '1) ? v : v + USB_DATA_NBIT'(1);
  endfunction

endpackage

// File: rtl/ad_pkt_encoder.sv
// AD sample packetiser: frames sample words into header/payload/checksum
// packets and writes them into one of two ping-pong banks of the TX buffer.
module ad_pkt_encoder
  import ad_pkt_encoder_pkg::*;
#(
  parameter int unsigned              PKT_SAMPLES = MAX_PKT_SAMPLES,
  parameter logic [USB_DATA_NBIT-1:0] PKT_HDR     = PKT_HDR_DEFAULT
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     s_vd,
  input  logic [USB_DATA_NBIT-1:0] s_data,
  output logic                     s_rdy,
  output logic                     tx_vd,
  output logic [TX_ADDR_NBIT-1:0]  tx_addr,
  output logic [USB_DATA_NBIT-1:0] tx_data,
  output logic                     tx_eop,
  output logic                     tx_bank,
  input  logic                     tx_ack,
  input  logic                     tx_ack_bank,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR0    = 3'd1,
    HDR1    = 3'd2,
    HDR2    = 3'd3,
    PAYLOAD = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [USB_ADDR_NBIT-1:0] IDX_HDR0     = USB_ADDR_NBIT'(0);
  localparam logic [USB_ADDR_NBIT-1:0] IDX_HDR1     = USB_ADDR_NBIT'(1);
  localparam logic [USB_ADDR_NBIT-1:0] IDX_HDR2     = USB_ADDR_NBIT'(2);
  localparam logic [USB_ADDR_NBIT-1:0] PAYLOAD_BASE = USB_ADDR_NBIT'(3);
  localparam logic [USB_ADDR_NBIT-1:0] LAST_SAMPLE  = USB_ADDR_NBIT'(PKT_SAMPLES - 1);
  localparam logic [USB_ADDR_NBIT-1:0] CSUM_IDX     = USB_ADDR_NBIT'(PKT_SAMPLES + 3);

  state_t                   state;
  logic                     cur_bank;
  logic [1:0]               bank_busy;
  logic [USB_DATA_NBIT-1:0] seq;
  logic [USB_DATA_NBIT-1:0] drop_cnt;
  logic [USB_DATA_NBIT-1:0] csum_acc;
  logic [USB_ADDR_NBIT-1:0] sample_cnt;
  logic                     accept_c;
  logic                     drop_c;

  // Sample handshake outcome for this cycle
  assign accept_c = s_vd && s_rdy;
  assign drop_c   = s_vd && !s_rdy;

  // Packet FSM with registered TX write port, handshake and bank bookkeeping
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_bank   <= 1'b0;
      bank_busy  <= 2'b00;
      seq        <= '0;
      drop_cnt   <= '0;
      csum_acc   <= '0;
      sample_cnt <= '0;
      s_rdy      <= 1'b0;
      tx_vd      <= 1'b0;
      tx_addr    <= '0;
      tx_data    <= '0;
      tx_eop     <= 1'b0;
      tx_bank    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_vd  <= 1'b0;
      tx_eop <= 1'b0;

      // Samples offered while not ready are lost but counted; the count
      // restarts when it is published in word 2
      if (state == HDR2) begin
        drop_cnt <= drop_c ? USB_DATA_NBIT'(1) : '0;
      end else if (drop_c) begin
        drop_cnt <= sat_inc(drop_cnt);
      end

      // Drained bank becomes free again; a DONE set below overrides this
      if (tx_ack) begin
        bank_busy[tx_ack_bank] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && !bank_busy[cur_bank]) begin
            state <= HDR0;
            busy  <= 1'b1;
          end
        end

        HDR0: begin
          tx_vd      <= 1'b1;
          tx_addr    <= {cur_bank, IDX_HDR0};
          tx_data    <= PKT_HDR;
          csum_acc   <= PKT_HDR;
          sample_cnt <= '0;
          state      <= HDR1;
        end

        HDR1: begin
          tx_vd    <= 1'b1;
          tx_addr  <= {cur_bank, IDX_HDR1};
          tx_data  <= seq;
          csum_acc <= csum_acc + seq;
          state    <= HDR2;
        end

        HDR2: begin
          tx_vd    <= 1'b1;
          tx_addr  <= {cur_bank, IDX_HDR2};
          tx_data  <= drop_cnt;
          csum_acc <= csum_acc + drop_cnt;
          s_rdy    <= 1'b1;
          state    <= PAYLOAD;
        end

        PAYLOAD: begin
          if (accept_c) begin
            tx_vd      <= 1'b1;
            tx_addr    <= {cur_bank, PAYLOAD_BASE + sample_cnt};
            tx_data    <= s_data;
            csum_acc   <= csum_acc + s_data;
            sample_cnt <= sample_cnt + USB_ADDR_NBIT'(1);
            if (sample_cnt == LAST_SAMPLE) begin
              s_rdy <= 1'b0;
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          tx_vd   <= 1'b1;
          tx_addr <= {cur_bank, CSUM_IDX};
          tx_data <= csum_acc;
          state   <= DONE;
        end

        DONE: begin
          tx_eop              <= 1'b1;
          tx_bank             <= cur_bank;
          bank_busy[cur_bank] <= 1'b1;
          cur_bank            <= ~cur_bank;
          seq                 <= seq + USB_DATA_NBIT'(1);
          busy                <= 1'b0;
          state               <= IDLE;
        end

        default: begin
          s_rdy <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ad_pkt_encoder.md
AD_PKT_ENCODER -- requirements
Module: ad_pkt_encoder

Interface
REQ-001 Parameter PKT_SAMPLES, default 252, sample words per packet; legal range 1..252.
REQ-002 Parameter PKT_HDR, default 16'hA55A, packet header word 0.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 mclk  in  1  sole clock; all ports synchronous to it.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 enable  in  1  start new packets while high.
REQ-007 s_vd  in  1  sample valid.
REQ-008 s_data  in  `USB_DATA_NBIT (16)  sample word.
REQ-009 s_rdy  out  1  sample accepted when s_vd&&s_rdy.
REQ-010 tx_vd  out  1  TX buffer write enable.
REQ-011 tx_addr  out  `USB_ADDR_NBIT+1 (9)  {bank, word index}.
REQ-012 tx_data  out  `USB_DATA_NBIT (16)  TX buffer write data.
REQ-013 tx_eop  out  1  one-cycle pulse: packet complete in bank tx_bank.
REQ-014 tx_bank  out  1  bank of the completed packet, valid with tx_eop.
REQ-015 tx_ack  in  1  one-cycle pulse: slave-FIFO side has drained bank tx_ack_bank.
REQ-016 tx_ack_bank  in  1  bank released by tx_ack.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Packet layout SHALL be: word0 PKT_HDR; word1 sequence number; word2 drop count; words 3..PKT_SAMPLES+2 samples in arrival order; word PKT_SAMPLES+3 checksum.
REQ-019 FSM states SHALL be IDLE, HDR0, HDR1, HDR2, PAYLOAD, CSUM, DONE.
REQ-020 IDLE->HDR0 when enable=1 and the current bank is not busy; otherwise stay in IDLE.
REQ-021 HDR0, HDR1, HDR2 SHALL each take one cycle, writing words 0, 1, 2 with tx_vd=1, then go to PAYLOAD.
REQ-022 In PAYLOAD, s_rdy SHALL be 1; each accepted sample SHALL be written in the same cycle at index 3+k.
REQ-023 After sample PKT_SAMPLES-1 is accepted, the FSM SHALL go to CSUM.
REQ-024 s_rdy SHALL be 0 in every state except PAYLOAD.
REQ-025 CSUM SHALL write the checksum (16-bit wrap-around sum of words 0..PKT_SAMPLES+2) in one cycle, then go to DONE.
REQ-026 DONE (one cycle) SHALL:
  - pulse tx_eop with tx_bank = current bank;
  - set that bank's busy flag;
  - toggle the current bank;
  - increment seq (16-bit, wraps 0xFFFF->0);
  - go to IDLE.
REQ-027 tx_ack SHALL clear busy[tx_ack_bank]; if a set and a clear hit the same bank in the same cycle, the set wins.
REQ-028 Both banks busy: the FSM SHALL hold in IDLE; no TX writes.
REQ-029 s_vd=1 with s_rdy=0 SHALL drop the sample and increment drop_cnt, saturating at 0xFFFF.
REQ-030 drop_cnt SHALL be cleared when written in HDR2; a drop in that same cycle SHALL leave drop_cnt=1.
REQ-031 Deasserting enable mid-packet SHALL NOT abort the packet; it only blocks the next IDLE->HDR0 transition.
REQ-032 Write latency is zero: tx_vd/tx_addr/tx_data SHALL be registered outputs valid in the state's cycle; no other pipelining.

Reset
REQ-033 On rst_n=0 at a clock edge, the block SHALL reset to:
  - state IDLE, current bank 0, both busy flags 0;
  - seq, drop_cnt, checksum accumulator and sample counter 0;
  - s_rdy, tx_vd, tx_eop, busy 0; tx_addr, tx_data, tx_bank 0.
REQ-034 Reset mid-packet SHALL abandon the partial packet with no tx_eop.

Structure
REQ-035 `USB_ADDR_NBIT, `USB_DATA_NBIT and the default header value SHALL live in globals.v.
REQ-036 State encodings SHALL be local to the module.
REQ-037 The block SHALL be single-module, with no sub-module.
REQ-038 tx_* SHALL connect directly to the write port of the existing 512x16 buffered_ram.

Verification
REQ-039 PKT_SAMPLES=4, enable=1, samples 1,2,3,4 -> bank-0 writes A55A,0000,0000,0001..0004,A564; tx_eop with tx_bank=0.
REQ-040 Two packets with no tx_ack -> both banks busy; third packet not started; tx_ack with tx_ack_bank=0 -> third packet written to bank 0 with seq=2.
REQ-041 s_vd held high through header -> 3 drops per packet; next packet word2=0003; checksum includes it.
REQ-042 enable dropped after HDR1 -> packet completes, tx_eop fires, FSM then idles.
REQ-043 rst_n low during PAYLOAD -> next cycle all outputs 0; next packet uses bank 0 with seq 0.
REQ-044 seq preset near 0xFFFF (0x10000 packets, or force) -> word1 FFFF then 0000.
